// File: rtl/tl_math_seq_if.sv
// Handshake bundle between the top-level FSM, the TL_Math sub-FSMs and the sequencer.
// The slave modport is the sequencer; the master modport is everything around it.
interface tl_math_seq_if #(
  parameter int NUM_STAGES = 4,
  parameter int SEL_W      = 2
);
  logic                  start;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] done_in;
  logic [NUM_STAGES-1:0] start_out;
  logic [SEL_W-1:0]      sel;
  logic                  grant;
  logic                  busy;
  logic                  done;
  logic [15:0]           frame_count;
  logic                  timeout_err;

  modport master (
    output start, stage_en, done_in,
    input  start_out, sel, grant, busy, done, frame_count, timeout_err
  );

  modport slave (
    input  start, stage_en, done_in,
    output start_out, sel, grant, busy, done, frame_count, timeout_err
  );
endinterface

// File: rtl/tl_math_sequencer.sv
// Launches each enabled TL_Math stage in order and owns the shared-datapath select.
// Define TL_MATH_SEQ_WATCHDOG_EN to compile in the WAIT-state watchdog (timeout_err).
module tl_math_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int SEL_W      = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic         clock,
  input  logic         reset,
  tl_math_seq_if.slave bus
);
  if (NUM_STAGES < 2 || NUM_STAGES > (1 << SEL_W) || TIMEOUT < 1) begin : g_param_check
    $error("tl_math_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_NEXT, S_FINISH} state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } first_t;

  // Lowest set bit of mask at index lo or above.
  function automatic first_t first_set(input logic [NUM_STAGES-1:0] mask, input int lo);
    first_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mask[i] && i >= lo) begin
        r.found = 1'b1;
        r.idx   = SEL_W'(i);
      end
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] en_q, en_d;
  logic [15:0]           frame_count_q;
  first_t                first_start, first_next;

  logic [NUM_STAGES-1:0] start_out_c;
  logic [SEL_W-1:0]      sel_c;
  logic                  grant_c, busy_c, done_c;

`ifdef TL_MATH_SEQ_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;
`endif

  assign first_start = first_set(bus.stage_en, 0);
  assign first_next  = first_set(en_q, int'(idx_q) + 1);

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    en_d        = en_q;
    start_out_c = '0;
    sel_c       = idx_q;
    grant_c     = 1'b0;
    busy_c      = 1'b1;
    done_c      = 1'b0;
`ifdef TL_MATH_SEQ_WATCHDOG_EN
    wd_cnt_d    = wd_cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        sel_c  = '0;
        busy_c = 1'b0;
        if (bus.start) begin
          en_d    = bus.stage_en;
          idx_d   = first_start.idx;
          state_d = first_start.found ? S_LAUNCH : S_FINISH;
`ifdef TL_MATH_SEQ_WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        start_out_c = NUM_STAGES'(1) << idx_q;
        grant_c     = 1'b1;
        state_d     = S_WAIT;
`ifdef TL_MATH_SEQ_WATCHDOG_EN
        wd_cnt_d    = '0;
`endif
      end
      S_WAIT: begin
        grant_c = 1'b1;
        if (bus.done_in[idx_q]) begin
          state_d = S_NEXT;
        end
`ifdef TL_MATH_SEQ_WATCHDOG_EN
        else begin
          // Expiry abandons the remaining stages but still closes the frame.
          wd_cnt_d = wd_cnt_q + 16'd1;
          if (wd_cnt_d == 16'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end
        end
`endif
      end
      S_NEXT: begin
        if (first_next.found) begin
          idx_d   = first_next.idx;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      en_q          <= '0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      if (state_q == S_FINISH) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

`ifdef TL_MATH_SEQ_WATCHDOG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.timeout_err = err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // Outputs decode the asynchronously reset state, so they drop as soon as reset asserts.
  assign bus.start_out   = start_out_c;
  assign bus.sel         = sel_c;
  assign bus.grant       = grant_c;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.frame_count = frame_count_q;
endmodule

// File: tb/tb_tl_math_sequencer.sv
// Self-checking bench for tl_math_sequencer: directed and random stage masks against a
// cycle-count model; the watchdog scenario runs when TL_MATH_SEQ_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_tl_math_sequencer;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tl_math_seq_if #(.NUM_STAGES(N), .SEL_W(SW)) bus ();

  tl_math_sequencer #(.NUM_STAGES(N), .SEL_W(SW), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_frames = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one sequence. Each enabled stage answers d cycles after its start pulse (d=0: never).
  task automatic run_seq(input string tag, input logic [3:0] en, input int d,
                         input bit stray, input bit restart);
    int exp_code = 0, got_code = 0, n_en = 0, first = -1;
    int exp_fin, exp_grant, exp_err;
    int pending[N];
    int cur = -1, done_cyc = -1, busy_cnt = 0, grant_cnt = 0, bad_sel = 0, bad_hot = 0;
    int idle_bad = 0;
    logic err_at_done = 1'b0;
    bit fin = 1'b0;

    // Reference: stages run in ascending index order; each costs d+2 cycles after cycle 0.
    for (int i = 0; i < N; i++) begin
      pending[i] = -1;
      if (en[i]) begin
        n_en++;
        exp_code = exp_code * 8 + i + 1;
        if (first < 0) first = i;
      end
    end
    exp_fin   = (n_en == 0) ? 1 : 1 + n_en * (d + 2);
    exp_grant = n_en * (d + 1);
    exp_err   = 0;
`ifdef TL_MATH_SEQ_WATCHDOG_EN
    if (d == 0 && n_en > 0) begin
      exp_code  = first + 1;
      exp_fin   = 2 + TO;
      exp_grant = 1 + TO;
      exp_err   = 1;
    end
`endif

    @(negedge clock);
    bus.stage_en = en;
    bus.start    = 1'b1;
    bus.done_in  = '0;
    for (int c = 1; c <= 300 && !fin; c++) begin
      @(negedge clock);
      bus.start    = restart && (c == 2);
      bus.stage_en = 4'($urandom);
      if (bus.busy) busy_cnt++;
      if (bus.start_out != '0) begin
        if ($countones(bus.start_out) != 1) bad_hot++;
        for (int i = 0; i < N; i++) begin
          if (bus.start_out[i]) begin
            cur      = i;
            got_code = got_code * 8 + i + 1;
            if (d > 0) pending[i] = c + d;
          end
        end
      end
      if (bus.grant) begin
        grant_cnt++;
        if (int'(bus.sel) != cur) bad_sel++;
      end
      if (bus.done) begin
        done_cyc    = c;
        err_at_done = bus.timeout_err;
        fin         = 1'b1;
      end
      for (int i = 0; i < N; i++) bus.done_in[i] = (pending[i] == c);
      if (stray && cur == 1 && bus.grant && bus.start_out == '0) bus.done_in[2] = 1'b1;
    end
    bus.done_in = '0;
    bus.start   = 1'b0;

    exp_frames = exp_frames + 16'd1;
    check({tag, " done_seen"}, 32'(fin), 32'd1);
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_fin));
    check({tag, " launch_order"}, 32'(got_code), 32'(exp_code));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_fin));
    check({tag, " grant_cycles"}, 32'(grant_cnt), 32'(exp_grant));
    check({tag, " sel_vs_stage"}, 32'(bad_sel), 32'd0);
    check({tag, " start_onehot"}, 32'(bad_hot), 32'd0);
    check({tag, " timeout_err"}, 32'(err_at_done), 32'(exp_err));

    // Three idle cycles: no queued restart, select parked at 0, counter updated.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (bus.busy || bus.grant || bus.done || bus.start_out != '0 || bus.sel != '0) idle_bad++;
    end
    check({tag, " idle_after"}, 32'(idle_bad), 32'd0);
    check({tag, " frame_count"}, 32'(bus.frame_count), 32'(exp_frames));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.start    = 1'b1;
    bus.stage_en = 4'hF;
    bus.done_in  = '0;
    reset        = 1'b0;
    repeat (3) @(negedge clock);
    check("rst start_out", 32'(bus.start_out), 32'd0);
    check("rst sel_grant_busy_done", {28'd0, bus.sel, bus.grant, bus.busy}, 32'd0);
    check("rst done_err", {30'd0, bus.done, bus.timeout_err}, 32'd0);
    check("rst frame_count", 32'(bus.frame_count), 32'd0);

    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clock);
    check("idle after release", {27'd0, bus.start_out, bus.busy}, 32'd0);

    run_seq("all4", 4'b1111, 5, 1'b0, 1'b0);
    run_seq("alt", 4'b1010, int'($urandom_range(1, 4)), 1'b0, 1'b0);
    run_seq("empty", 4'b0000, 1, 1'b0, 1'b0);
    run_seq("stray_restart", 4'b0110, 3, 1'b1, 1'b1);
    for (int r = 0; r < 6; r++) begin
      run_seq("rand", 4'($urandom_range(1, 15)), int'($urandom_range(1, 6)),
              1'($urandom_range(0, 1)), 1'b1);
    end

`ifdef TL_MATH_SEQ_WATCHDOG_EN
    run_seq("wd_expire", 4'b0011, 0, 1'b0, 1'b0);
    check("wd sticky", 32'(bus.timeout_err), 32'd1);
    run_seq("wd_cleared", 4'b0001, 2, 1'b0, 1'b0);
`endif

    force dut.frame_count_q = 16'hFFFF;
    @(negedge clock);
    release dut.frame_count_q;
    exp_frames = 16'hFFFF;
    @(negedge clock);
    check("preload frame_count", 32'(bus.frame_count), 32'h0000FFFF);
    run_seq("wrap", 4'b0000, 1, 1'b0, 1'b0);

    // Reset mid-WAIT must drop grant without waiting for a clock edge.
    @(negedge clock);
    bus.stage_en = 4'b0100;
    bus.start    = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    check("pre-reset grant", 32'(bus.grant), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async reset grant", 32'(bus.grant), 32'd0);
    check("async reset busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    check("async reset frame_count", 32'(bus.frame_count), 32'd0);
    exp_frames = '0;
    @(negedge clock);
    reset = 1'b1;
    run_seq("post_reset", 4'($urandom_range(1, 15)), 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
